// File: rtl/dump_loader_if.sv
// SD sector reader + SDRAM write port bundle used by the dump loader.
// master = the loader side, slave = the SD reader / memory controller side.
interface dump_loader_if #(
    parameter int unsigned ADDR_W = 24
);
    logic              sd_rd_req;
    logic [31:0]       sd_sector;
    logic              sd_rd_ack;
    logic [7:0]        sd_data;
    logic              sd_valid;
    logic              sd_ready;
    logic              sd_error;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_data;
    logic              mem_wr;
    logic              mem_ready;

    modport master (
        output sd_rd_req, sd_sector, sd_ready, mem_addr, mem_data, mem_wr,
        input  sd_rd_ack, sd_data, sd_valid, sd_error, mem_ready
    );

    modport slave (
        input  sd_rd_req, sd_sector, sd_ready, mem_addr, mem_data, mem_wr,
        output sd_rd_ack, sd_data, sd_valid, sd_error, mem_ready
    );
endinterface

// File: rtl/dump_loader.sv
// Copies a ROM dump (PRG sectors then CHR sectors) from the SD sector reader
// into SDRAM through a small tagged byte FIFO. Holds the NES core via
// loader_busy while copying and pulses load_done when finished or aborted on error.
module dump_loader #(
    parameter int unsigned       ADDR_W     = 24,
    parameter logic [ADDR_W-1:0] PRG_BASE   = 24'h000000,
    parameter logic [ADDR_W-1:0] CHR_BASE   = 24'h800000,
    parameter int unsigned       FIFO_DEPTH = 8
) (
    input  logic                sysclk,
    input  logic                reset,
    input  logic                load_dump,
    input  logic [31:0]         dump_offset,
    input  logic [15:0]         dump_prg_len,
    input  logic [15:0]         dump_chr_len,
    dump_loader_if.master       bus,
    output logic                loader_busy,
    output logic                load_done,
    output logic                load_err
);

    localparam int unsigned   AW        = $clog2(FIFO_DEPTH);
    localparam int unsigned   CW        = AW + 1;
    localparam logic [CW-1:0] FIFO_FULL = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, REQ, STREAM, DRAIN, DONE, ERR} state_t;

    state_t            state, state_nxt;
    logic [31:0]       lba;
    logic [15:0]       prg_rem, chr_rem;
    logic              cur_chr;
    logic [8:0]        byte_cnt;
    logic [ADDR_W-1:0] prg_ptr, chr_ptr;

    // FIFO entry: {phase tag (1 = CHR), data byte}
    logic [8:0]        fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]     rd_ptr, wr_ptr;
    logic [CW-1:0]     fifo_cnt;
    logic [8:0]        head;

    logic fifo_empty, fifo_full, sd_ready_i, err_hit, push, pop, flush_keep;
    logic sect_left, desc_nz;

    assign fifo_empty = (fifo_cnt == '0);
    assign fifo_full  = (fifo_cnt == FIFO_FULL);
    assign head       = fifo_mem[rd_ptr];
    assign sd_ready_i = (state == STREAM) && !fifo_full;
    assign err_hit    = bus.sd_error && (state == REQ || state == STREAM);
    // A byte racing an error or a restart belongs to a copy that is being thrown away.
    assign push       = bus.sd_valid && sd_ready_i && !load_dump && !err_hit;
    assign pop        = !fifo_empty && bus.mem_ready;
    assign flush_keep = err_hit && !load_dump;
    assign sect_left  = (prg_rem != '0) || (chr_rem != '0);
    assign desc_nz    = (dump_prg_len != '0) || (dump_chr_len != '0);

    // State register
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state and outputs; load_dump overrides everything, then sd_error
    always_comb begin
        state_nxt     = state;
        bus.sd_rd_req = 1'b0;
        bus.sd_sector = '0;
        bus.sd_ready  = sd_ready_i;
        bus.mem_wr    = !fifo_empty;
        bus.mem_addr  = '0;
        bus.mem_data  = '0;
        loader_busy   = 1'b0;
        load_done     = 1'b0;
        if (!fifo_empty) begin
            bus.mem_addr = head[8] ? chr_ptr : prg_ptr;
            bus.mem_data = head[7:0];
        end
        case (state)
            IDLE: ;
            REQ: begin
                loader_busy   = 1'b1;
                bus.sd_rd_req = 1'b1;
                bus.sd_sector = lba;
                if (bus.sd_rd_ack) state_nxt = STREAM;
            end
            STREAM: begin
                loader_busy = 1'b1;
                if (push && byte_cnt == 9'd511) state_nxt = sect_left ? REQ : DRAIN;
            end
            DRAIN: begin
                loader_busy = 1'b1;
                if (fifo_empty) state_nxt = DONE;
            end
            DONE: begin
                load_done = 1'b1;
                state_nxt = IDLE;
            end
            ERR: begin
                // wait for the one in-flight write kept at the error to be accepted
                loader_busy = 1'b1;
                if (fifo_empty) state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
        if (err_hit)   state_nxt = ERR;
        if (load_dump) state_nxt = desc_nz ? REQ : DONE;
    end

    // Descriptor, sector accounting and per-phase write pointers
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            lba      <= '0;
            prg_rem  <= '0;
            chr_rem  <= '0;
            cur_chr  <= 1'b0;
            byte_cnt <= '0;
            prg_ptr  <= PRG_BASE;
            chr_ptr  <= CHR_BASE;
            load_err <= 1'b0;
        end else if (load_dump) begin
            lba      <= dump_offset;
            prg_rem  <= dump_prg_len;
            chr_rem  <= dump_chr_len;
            cur_chr  <= 1'b0;
            byte_cnt <= '0;
            prg_ptr  <= PRG_BASE;
            chr_ptr  <= CHR_BASE;
            load_err <= 1'b0;
        end else begin
            if (err_hit) load_err <= 1'b1;
            // The phase of a sector is fixed when its read is accepted; CHR LBAs
            // simply follow the PRG ones because lba keeps counting.
            if (state == REQ && bus.sd_rd_ack && !err_hit) begin
                lba      <= lba + 32'd1;
                byte_cnt <= '0;
                if (prg_rem != '0) begin
                    prg_rem <= prg_rem - 16'd1;
                    cur_chr <= 1'b0;
                end else begin
                    chr_rem <= chr_rem - 16'd1;
                    cur_chr <= 1'b1;
                end
            end
            if (push) byte_cnt <= byte_cnt + 9'd1;
            if (pop) begin
                if (head[8]) chr_ptr <= chr_ptr + ADDR_W'(1);
                else         prg_ptr <= prg_ptr + ADDR_W'(1);
            end
        end
    end

    // FIFO pointers; an SD error keeps only the head if it is still waiting on mem_ready
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            fifo_cnt <= '0;
        end else if (load_dump || (flush_keep && (pop || fifo_empty))) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            fifo_cnt <= '0;
        end else if (flush_keep) begin
            wr_ptr   <= rd_ptr + AW'(1);
            fifo_cnt <= CW'(1);
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
        end
    end

    // FIFO storage
    always_ff @(posedge sysclk) begin
        if (push) fifo_mem[wr_ptr] <= {cur_chr, bus.sd_data};
    end

endmodule

// File: tb/tb_dump_loader.sv
// Bench for dump_loader: SD sector reader model pushes expected SDRAM writes
// into a scoreboard queue; the memory model pops and compares each accepted write.
module tb_dump_loader;
    localparam int          ADDR_W   = 24;
    localparam logic [23:0] PRG_BASE = 24'h000000;
    localparam logic [23:0] CHR_BASE = 24'h800000;

    logic        sysclk = 1'b0;
    logic        reset  = 1'b0;
    logic        load_dump = 1'b0;
    logic [31:0] dump_offset = '0;
    logic [15:0] dump_prg_len = '0, dump_chr_len = '0;
    logic        loader_busy, load_done, load_err;

    dump_loader_if #(.ADDR_W(ADDR_W)) bus ();

    dump_loader #(
        .ADDR_W(ADDR_W), .PRG_BASE(PRG_BASE), .CHR_BASE(CHR_BASE), .FIFO_DEPTH(8)
    ) dut (
        .sysclk(sysclk), .reset(reset), .load_dump(load_dump), .dump_offset(dump_offset),
        .dump_prg_len(dump_prg_len), .dump_chr_len(dump_chr_len), .bus(bus),
        .loader_busy(loader_busy), .load_done(load_done), .load_err(load_err)
    );

    always #5 sysclk = ~sysclk;

    int errors = 0, checks = 0;
    logic [31:0] exp_q[$];
    logic [31:0] lba_q[$];
    int  done_cnt = 0, wr_cnt = 0, throttle_cnt = 0, load_gen = 0, tb_prg = 0, err_idx = 0;
    bit  done_busy = 1'b0;
    bit  sd_kill = 1'b0, mem_hold = 1'b0, mem_rand = 1'b0, sd_bursty = 1'b0, err_en = 1'b0;

    function automatic logic [7:0] pat(input logic [31:0] l, input int i);
        logic [31:0] v;
        v = l * 32'd13 + 32'(i) * 32'd7 + 32'(i >>> 8);
        return v[7:0];
    endfunction

    // SD sector reader model
    initial begin : sd_model
        logic [31:0] cur;
        logic [23:0] base;
        int idx, sect_k, seen_gen, dly;
        bit prev;
        sect_k = 0; seen_gen = 0;
        bus.sd_rd_ack = 1'b0; bus.sd_valid = 1'b0; bus.sd_data = '0; bus.sd_error = 1'b0;
        forever begin
            @(negedge sysclk);
            if (bus.sd_rd_req && !sd_kill) begin
                if (seen_gen != load_gen) begin sect_k = 0; seen_gen = load_gen; end
                dly = $urandom_range(0, 2);
                repeat (dly) @(negedge sysclk);
                cur = bus.sd_sector;
                lba_q.push_back(cur);
                bus.sd_rd_ack = 1'b1;
                @(negedge sysclk);
                bus.sd_rd_ack = 1'b0;
                base = (sect_k < tb_prg) ? PRG_BASE + 24'(sect_k * 512)
                                         : CHR_BASE + 24'((sect_k - tb_prg) * 512);
                idx = 0; prev = 1'b0;
                forever begin
                    if (prev) begin
                        exp_q.push_back({base + 24'(idx), pat(cur, idx)});
                        idx++;
                    end
                    if (idx == 512 || sd_kill) break;
                    if (err_en && idx == err_idx) begin
                        bus.sd_valid = 1'b0; bus.sd_error = 1'b1;
                        @(negedge sysclk);
                        bus.sd_error = 1'b0;
                        break;
                    end
                    bus.sd_valid = sd_bursty ? ($urandom_range(0, 99) < 55) : 1'b1;
                    bus.sd_data  = pat(cur, idx);
                    prev = bus.sd_valid && bus.sd_ready;
                    if (bus.sd_valid && !bus.sd_ready) throttle_cnt++;
                    @(negedge sysclk);
                end
                bus.sd_valid = 1'b0;
                sect_k++;
            end
        end
    end

    // SDRAM model and scoreboard check
    initial begin : mem_model
        logic [31:0] e;
        bus.mem_ready = 1'b0;
        forever begin
            @(negedge sysclk);
            bus.mem_ready = mem_hold ? 1'b0 : (mem_rand ? ($urandom_range(0, 99) < 30) : 1'b1);
            if (bus.mem_wr && bus.mem_ready) begin
                checks++; wr_cnt++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL mem_write: got addr=%h data=%h, expected no write", bus.mem_addr, bus.mem_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({bus.mem_addr, bus.mem_data} !== e) begin
                        errors++;
                        $display("FAIL mem_write: got addr=%h data=%h, expected addr=%h data=%h",
                                 bus.mem_addr, bus.mem_data, e[31:8], e[7:0]);
                    end
                end
            end
        end
    end

    // load_done pulse counter
    initial begin : done_mon
        forever begin
            @(negedge sysclk);
            if (load_done) begin done_cnt++; done_busy = loader_busy; end
        end
    end

    task automatic start_load(input logic [31:0] off, input int prg, input int chr);
        dump_offset = off; dump_prg_len = 16'(prg); dump_chr_len = 16'(chr);
        tb_prg = prg; load_gen++;
        exp_q.delete(); lba_q.delete();
        load_dump = 1'b1;
        @(negedge sysclk);
        load_dump = 1'b0;
    endtask

    task automatic wait_done(input int budget, input int base_cnt, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (done_cnt > base_cnt) begin ok = 1'b1; break; end
            @(negedge sysclk);
        end
    endtask

    task automatic wait_writes(input int budget, input int target, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (wr_cnt >= target) begin ok = 1'b1; break; end
            @(negedge sysclk);
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge sysclk);
        checks++;
        if ({bus.sd_rd_req, bus.sd_sector, bus.sd_ready} !== '0) begin
            errors++; $display("FAIL reset_sd: req=%b sector=%h ready=%b, expected all 0",
                               bus.sd_rd_req, bus.sd_sector, bus.sd_ready);
        end
        checks++;
        if ({bus.mem_wr, bus.mem_addr, bus.mem_data} !== '0) begin
            errors++; $display("FAIL reset_mem: wr=%b addr=%h data=%h, expected all 0",
                               bus.mem_wr, bus.mem_addr, bus.mem_data);
        end
        checks++;
        if ({loader_busy, load_done, load_err} !== 3'b000) begin
            errors++; $display("FAIL reset_status: busy/done/err=%b%b%b, expected 000",
                               loader_busy, load_done, load_err);
        end
        reset = 1'b1;
        @(negedge sysclk);
    endtask

    task automatic test_single;
        int base, wb; bit ok;
        mem_rand = 1'b0; sd_bursty = 1'b0;
        base = done_cnt; wb = wr_cnt;
        checks++;
        if (loader_busy !== 1'b0) begin errors++; $display("FAIL single_idle_busy: got %b expected 0", loader_busy); end
        start_load(32'd100, 1, 0);
        checks++;
        if (loader_busy !== 1'b1) begin errors++; $display("FAIL single_busy_rise: got %b expected 1", loader_busy); end
        wait_done(3000, base, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL single_done_timeout: got no load_done, expected one"); end
        repeat (3) @(negedge sysclk);
        checks++;
        if (lba_q.size() != 1 || lba_q[0] !== 32'd100) begin
            errors++; $display("FAIL single_lba: got %0d requests, expected 1 at LBA 100", lba_q.size());
        end
        checks++;
        if (wr_cnt - wb != 512 || exp_q.size() != 0) begin
            errors++; $display("FAIL single_writes: got %0d writes (%0d missing), expected 512", wr_cnt - wb, exp_q.size());
        end
        checks++;
        if (done_cnt - base != 1 || done_busy !== 1'b0 || loader_busy !== 1'b0) begin
            errors++; $display("FAIL single_done: got %0d pulses busy_at_done=%b, expected 1 pulse busy 0", done_cnt - base, done_busy);
        end
    endtask

    task automatic test_prg_chr_random;
        int base, wb, tb0; bit ok;
        mem_rand = 1'b1; sd_bursty = 1'b1;
        base = done_cnt; wb = wr_cnt; tb0 = throttle_cnt;
        start_load(32'd7, 2, 1);
        wait_done(20000, base, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL prgchr_done_timeout: got no load_done, expected one"); end
        repeat (3) @(negedge sysclk);
        checks++;
        if (lba_q.size() != 3 || lba_q[0] !== 32'd7 || lba_q[1] !== 32'd8 || lba_q[2] !== 32'd9) begin
            errors++; $display("FAIL prgchr_lba: got %0d requests first=%0d, expected LBAs 7,8,9", lba_q.size(), lba_q[0]);
        end
        checks++;
        if (wr_cnt - wb != 1536 || exp_q.size() != 0) begin
            errors++; $display("FAIL prgchr_writes: got %0d writes (%0d missing), expected 1536", wr_cnt - wb, exp_q.size());
        end
        checks++;
        if (throttle_cnt == tb0) begin errors++; $display("FAIL prgchr_throttle: got no sd_ready backpressure, expected some"); end
        checks++;
        if (done_cnt - base != 1) begin errors++; $display("FAIL prgchr_done_count: got %0d expected 1", done_cnt - base); end
        mem_rand = 1'b0; sd_bursty = 1'b0;
    endtask

    task automatic test_boundary;
        int base, wb; bit ok;
        base = done_cnt; wb = wr_cnt;
        start_load(32'hFFFF_FFFF, 1, 1);
        wait_done(4000, base, ok);
        repeat (3) @(negedge sysclk);
        checks++;
        if (!ok || lba_q.size() != 2 || lba_q[0] !== 32'hFFFF_FFFF || lba_q[1] !== 32'd0) begin
            errors++; $display("FAIL lba_wrap: done=%b requests=%0d, expected LBAs ffffffff,0", ok, lba_q.size());
        end
        checks++;
        if (wr_cnt - wb != 1024 || exp_q.size() != 0) begin
            errors++; $display("FAIL lba_wrap_writes: got %0d writes, expected 1024", wr_cnt - wb);
        end
        base = done_cnt; wb = wr_cnt;
        start_load(32'd5, 0, 1);
        wait_done(3000, base, ok);
        repeat (3) @(negedge sysclk);
        checks++;
        if (!ok || lba_q.size() != 1 || lba_q[0] !== 32'd5 || wr_cnt - wb != 512 || exp_q.size() != 0) begin
            errors++; $display("FAIL chr_only: done=%b requests=%0d writes=%0d, expected 1 request at 5 and 512 writes",
                               ok, lba_q.size(), wr_cnt - wb);
        end
    endtask

    task automatic test_sd_error;
        int base, wb; bit ok;
        base = done_cnt;
        mem_hold = 1'b1; err_en = 1'b1; err_idx = 5;
        start_load(32'd40, 2, 0);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (load_err) begin ok = 1'b1; break; end
            @(negedge sysclk);
        end
        err_en = 1'b0;
        checks++;
        if (!ok) begin errors++; $display("FAIL err_flag_timeout: load_err never set, expected 1"); end
        checks++;
        if (bus.mem_wr !== 1'b1 || bus.mem_addr !== PRG_BASE || bus.mem_data !== pat(32'd40, 0) || loader_busy !== 1'b1) begin
            errors++; $display("FAIL err_pending: wr=%b addr=%h data=%h busy=%b, expected 1 %h %h 1",
                               bus.mem_wr, bus.mem_addr, bus.mem_data, loader_busy, PRG_BASE, pat(32'd40, 0));
        end
        while (exp_q.size() > 1) void'(exp_q.pop_back());
        wb = wr_cnt;
        mem_hold = 1'b0;
        wait_done(100, base, ok);
        repeat (2) @(negedge sysclk);
        checks++;
        if (!ok || done_busy !== 1'b0) begin errors++; $display("FAIL err_done: done=%b busy_at_done=%b, expected 1 0", ok, done_busy); end
        checks++;
        if (wr_cnt - wb != 1 || bus.mem_wr !== 1'b0 || exp_q.size() != 0) begin
            errors++; $display("FAIL err_flush: got %0d writes after error, mem_wr=%b, expected 1 then 0", wr_cnt - wb, bus.mem_wr);
        end
        checks++;
        if (load_err !== 1'b1 || lba_q.size() != 1) begin
            errors++; $display("FAIL err_sticky: load_err=%b requests=%0d, expected 1 and 1", load_err, lba_q.size());
        end
    endtask

    task automatic test_zero_len;
        int base;
        base = done_cnt;
        start_load(32'd9, 0, 0);
        checks++;
        if (load_done !== 1'b1 || loader_busy !== 1'b0 || bus.sd_rd_req !== 1'b0 || load_err !== 1'b0) begin
            errors++; $display("FAIL zero_len: done=%b busy=%b req=%b err=%b, expected 1 0 0 0",
                               load_done, loader_busy, bus.sd_rd_req, load_err);
        end
        @(negedge sysclk);
        checks++;
        if (load_done !== 1'b0) begin errors++; $display("FAIL zero_len_pulse: done=%b second cycle, expected 0", load_done); end
        repeat (5) @(negedge sysclk);
        checks++;
        if (done_cnt - base != 1 || lba_q.size() != 0) begin
            errors++; $display("FAIL zero_len_count: pulses=%0d requests=%0d, expected 1 0", done_cnt - base, lba_q.size());
        end
    endtask

    task automatic test_abort;
        int base, wb; bit ok;
        wb = wr_cnt;
        start_load(32'd200, 2, 0);
        wait_writes(2000, wb + 100, ok);
        sd_kill = 1'b1; mem_hold = 1'b1;
        repeat (2) @(negedge sysclk);
        checks++;
        if (!ok || loader_busy !== 1'b1) begin errors++; $display("FAIL abort_setup: writes_ok=%b busy=%b, expected 1 1", ok, loader_busy); end
        base = done_cnt;
        start_load(32'd300, 1, 0);
        wb = wr_cnt;
        sd_kill = 1'b0; mem_hold = 1'b0;
        wait_done(3000, base, ok);
        repeat (3) @(negedge sysclk);
        checks++;
        if (!ok || done_cnt - base != 1) begin errors++; $display("FAIL abort_done: pulses=%0d, expected 1", done_cnt - base); end
        checks++;
        if (lba_q.size() != 1 || lba_q[0] !== 32'd300 || wr_cnt - wb != 512 || exp_q.size() != 0) begin
            errors++; $display("FAIL abort_restart: requests=%0d first=%0d writes=%0d, expected 1 at 300 and 512",
                               lba_q.size(), lba_q[0], wr_cnt - wb);
        end
    endtask

    task automatic test_reset_mid;
        int base, wb; bit ok;
        wb = wr_cnt;
        start_load(32'd50, 1, 0);
        wait_writes(2000, wb + 50, ok);
        sd_kill = 1'b1; mem_hold = 1'b1;
        repeat (2) @(negedge sysclk);
        base = done_cnt;
        reset = 1'b0;
        #1;
        checks++;
        if (!ok || {bus.sd_rd_req, bus.sd_sector, bus.sd_ready, bus.mem_wr, bus.mem_addr, bus.mem_data,
                    loader_busy, load_done, load_err} !== '0) begin
            errors++; $display("FAIL reset_mid: req=%b ready=%b wr=%b addr=%h busy=%b done=%b, expected all 0",
                               bus.sd_rd_req, bus.sd_ready, bus.mem_wr, bus.mem_addr, loader_busy, load_done);
        end
        @(negedge sysclk);
        reset = 1'b1;
        exp_q.delete();
        sd_kill = 1'b0; mem_hold = 1'b0;
        repeat (20) @(negedge sysclk);
        checks++;
        if (done_cnt != base || loader_busy !== 1'b0 || bus.sd_rd_req !== 1'b0) begin
            errors++; $display("FAIL reset_mid_after: pulses=%0d busy=%b req=%b, expected 0 0 0",
                               done_cnt - base, loader_busy, bus.sd_rd_req);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_prg_chr_random();
        test_boundary();
        test_sd_error();
        test_zero_len();
        test_abort();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
